// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared FFT definitions: default frame size, sample packing fields and the
// bit-reversal helper used by the output reorder buffer.
package fft_bitrev_reorder_pkg;

  localparam int FFT_LOG2N   = 10;
  localparam int BITREV_MAXW = 16;

  // Samples are packed {imag, real}, each half of the sample width.
  localparam int RE_LSB_FRAC = 0;
  localparam int IM_LSB_FRAC = 1;

  // Reverses the low n bits of v; bits at n and above come back as zero.
  function automatic logic [BITREV_MAXW-1:0] bitrev(input logic [BITREV_MAXW-1:0] v,
                                                    input int n);
    logic [BITREV_MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAXW; i++) begin
      if (i < n) r[i] = v[n-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_mem.sv
// Single-port frame memory with synchronous write and registered read data.
module mem_single #(
  parameter int WD    = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [WD-1:0] din,
  output logic [WD-1:0] dout
);

  logic [WD-1:0] mem [DEPTH];

  // Contents are never reset; dout only updates on a read access.
  always_ff @(posedge clk) begin
    if (cs && we) mem[addr] <= din;
    if (cs && !we) dout <= mem[addr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer turning the bit-reversed FFT output stream into
// natural order with one frame of latency. FFT_REORDER_SOF_EN adds o_sof/o_eof.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N,
  parameter int WD    = 32
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          i_strb,
  input  logic [WD-1:0] i_data,
  output logic          o_strb,
  output logic [WD-1:0] o_data
`ifdef FFT_REORDER_SOF_EN
  ,
  output logic          o_sof,
  output logic          o_eof
`endif
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic [LOG2N-1:0] cnt;
  logic [LOG2N-1:0] cnt_rev;
  logic             bank;
  logic             primed;
  logic             rd_en;

  logic             cs0, we0, cs1, we1;
  logic [LOG2N-1:0] addr0, addr1;
  logic [WD-1:0]    dout0, dout1;

  logic             rd_v;
  logic             rd_sel;

  assign cnt_rev = LOG2N'(bitrev(BITREV_MAXW'(cnt), LOG2N));
  assign rd_en   = i_strb & primed;

  // The bank being written sees bit-reversed addresses; the other bank is read in order.
  assign cs0   = bank ? rd_en : i_strb;
  assign we0   = ~bank & i_strb;
  assign addr0 = bank ? cnt : cnt_rev;
  assign cs1   = bank ? i_strb : rd_en;
  assign we1   = bank & i_strb;
  assign addr1 = bank ? cnt_rev : cnt;

  mem_single #(.WD(WD), .DEPTH(N)) u_mem0 (
    .clk  (clk),
    .cs   (cs0),
    .we   (we0),
    .addr (addr0),
    .din  (i_data),
    .dout (dout0)
  );

  mem_single #(.WD(WD), .DEPTH(N)) u_mem1 (
    .clk  (clk),
    .cs   (cs1),
    .we   (we1),
    .addr (addr1),
    .din  (i_data),
    .dout (dout1)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt    <= '0;
      bank   <= 1'b0;
      primed <= 1'b0;
    end else if (i_strb) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        bank   <= ~bank;
        primed <= 1'b1;
      end
    end
  end

  // rd_sel remembers which memory was read, since bank may flip before dout is used.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_v   <= 1'b0;
      rd_sel <= 1'b0;
      o_strb <= 1'b0;
      o_data <= '0;
    end else begin
      rd_v   <= rd_en;
      rd_sel <= ~bank;
      o_strb <= rd_v;
      if (rd_v) o_data <= rd_sel ? dout1 : dout0;
    end
  end

`ifdef FFT_REORDER_SOF_EN
  logic rd_sof, rd_eof;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_sof <= 1'b0;
      rd_eof <= 1'b0;
      o_sof  <= 1'b0;
      o_eof  <= 1'b0;
    end else begin
      rd_sof <= rd_en & (cnt == '0);
      rd_eof <= rd_en & (cnt == LAST);
      o_sof  <= rd_sof;
      o_eof  <= rd_eof;
    end
  end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Testbench for fft_bitrev_reorder with LOG2N=3; checks o_sof/o_eof when
// FFT_REORDER_SOF_EN is defined.
module tb_fft_bitrev_reorder;

  localparam int LOG2N = 3;
  localparam int N     = 1 << LOG2N;
  localparam int WD    = 32;
  localparam int ORDER [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          i_strb = 1'b0;
  logic [WD-1:0] i_data = '0;
  logic          o_strb;
  logic [WD-1:0] o_data;
`ifdef FFT_REORDER_SOF_EN
  logic          o_sof, o_eof;
`endif

  fft_bitrev_reorder #(.LOG2N(LOG2N), .WD(WD)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .i_strb  (i_strb),
    .i_data  (i_data),
    .o_strb  (o_strb),
    .o_data  (o_data)
`ifdef FFT_REORDER_SOF_EN
    ,
    .o_sof   (o_sof),
    .o_eof   (o_eof)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WD-1:0] data;
    int            due;
    bit            sof;
    bit            eof;
  } exp_t;

  typedef struct {
    logic [WD-1:0] din;
    int            gap;
    bit            exp_valid;
    logic [WD-1:0] exp_data;
  } vec_t;

  exp_t          sb[$];
  vec_t          vecs[24];
  int            checks = 0;
  int            errors = 0;
  logic [WD-1:0] last_exp = '0;

  // Reference model: natural-order copy of the frame being written and the previous one.
  logic [WD-1:0] m_cur  [N];
  logic [WD-1:0] m_prev [N];
  int            m_cnt = 0;
  bit            m_primed = 0;

  function automatic int brev3(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  task automatic checkOutput(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    m_cnt    = 0;
    m_primed = 0;
  endtask

  // Drives one strobe then idles for gap cycles; entered and left at posedge+1.
  task automatic applyStimulus(input logic [WD-1:0] d, input int gap,
                               input bit use_tbl, input bit tbl_valid, input logic [WD-1:0] tbl_exp);
    exp_t e;
    e.due = cyc + 2;
    e.sof = (m_cnt == 0);
    e.eof = (m_cnt == N - 1);
    if (use_tbl) begin
      if (tbl_valid) begin
        e.data = tbl_exp;
        sb.push_back(e);
      end
    end else if (m_primed) begin
      e.data = m_prev[brev3(m_cnt)];
      sb.push_back(e);
    end
    m_cur[m_cnt] = d;
    if (m_cnt == N - 1) begin
      m_prev   = m_cur;
      m_primed = 1;
      m_cnt    = 0;
    end else begin
      m_cnt++;
    end
    i_strb = 1'b1;
    i_data = d;
    @(posedge clk);
    #1;
    i_strb = 1'b0;
    i_data = $urandom;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard consumer plus hold check on non-strobe cycles.
  always @(negedge clk) begin
    if (n_reset) begin
      if (o_strb) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_strb", o_strb, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("o_data", o_data, e.data);
          checkOutput("strb_time", WD'(cyc), WD'(e.due));
`ifdef FFT_REORDER_SOF_EN
          checkOutput("o_sof", WD'(o_sof), WD'(e.sof));
          checkOutput("o_eof", WD'(o_eof), WD'(e.eof));
`endif
          last_exp = e.data;
        end
      end else begin
        checkOutput("o_data_hold", o_data, last_exp);
`ifdef FFT_REORDER_SOF_EN
        checkOutput("marker_idle", WD'({o_sof, o_eof}), '0);
`endif
      end
    end
  end

  initial begin
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N; k++) begin
        vecs[f*N+k].din       = WD'(f*N + k);
        vecs[f*N+k].gap       = (f == 2) ? 5 : 0;
        vecs[f*N+k].exp_valid = (f > 0);
        vecs[f*N+k].exp_data  = (f > 0) ? WD'((f-1)*N + ORDER[k]) : '0;
      end
    end

    $display("[TB] reset state");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_strb", WD'(o_strb), '0);
    checkOutput("reset_data", o_data, '0);
    n_reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] table frames: first frame silent, then natural order");
    for (int i = 0; i < 24; i++)
      applyStimulus(vecs[i].din, vecs[i].gap, 1'b1, vecs[i].exp_valid, vecs[i].exp_data);

    $display("[TB] random gaps");
    for (int i = 0; i < 3 * N; i++)
      applyStimulus(WD'(32'h100 + i), $urandom_range(0, 6), 1'b0, 1'b0, '0);

    $display("[TB] reset mid second frame");
    repeat (13) applyStimulus($urandom, 0, 1'b0, 1'b0, '0);
    n_reset  = 1'b0;
    sb.delete();
    last_exp = '0;
    modelReset();
    #1;
    checkOutput("midrst_strb", WD'(o_strb), '0);
    checkOutput("midrst_data", o_data, '0);
`ifdef FFT_REORDER_SOF_EN
    checkOutput("midrst_marks", WD'({o_sof, o_eof}), '0);
`endif
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3 * N; i++)
      applyStimulus(WD'(32'h200 + i), (i % 3 == 0) ? 1 : 0, 1'b0, 1'b0, '0);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("sb_drained", WD'(sb.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output reorder buffer for the pipelined radix-2 SDF FFT. It sits after the last pipeline stage and consumes that stage's strobed stream, which arrives in bit-reversed frequency order. It emits the same samples in natural order (bin 0 first) with one frame of latency. It uses two ping-pong frame banks: one is written with bit-reversed addresses while the other is read in natural order.

## Interface
- LOG2N, default 10: log2 of the frame length N. The bench uses 3.
- WD, default 32: sample width, packed {imag[WD/2-1:0], real[WD/2-1:0]}. Passed through unmodified.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- n_reset  input  1  reset, asynchronous, active-low.
- i_strb  input  1  one input sample valid this cycle. Back-to-back strobes are legal.
- i_data  input  WD  input sample, sampled when i_strb=1.
- o_strb  output  1  one natural-order output sample valid this cycle.
- o_data  output  WD  output sample. Held between strobes.
- o_sof  output  1  present only with FFT_REORDER_SOF_EN. Marks bin 0.
- o_eof  output  1  present only with FFT_REORDER_SOF_EN. Marks bin N-1.

## Operation
State:
- cnt[LOG2N-1:0]: sample index within the frame.
- bank: the write bank. The read bank is ~bank.
- primed: set once a full frame has been written.
- Two memories, mem0 and mem1, each N x WD, single-port, synchronous read with registered dout.

On each i_strb:
- Write: bank[bank] gets i_data at address bitrev(cnt). bitrev reverses all LOG2N bits.
- Read: if primed=1, issue a read of bank[~bank] at address cnt (natural order). This read uses the other memory, so there is no port conflict.
- Count: cnt <= cnt+1, wrapping from N-1 to 0.
- Frame wrap: when cnt == N-1, toggle bank and set primed (it stays 1).

Output pacing and draining:
- One output is produced per input strobe once primed. The output rate equals the input rate.
- There is no autonomous drain. The last frame is emitted only while the next frame is being written.

The first frame after reset produces no o_strb.

Write order determines what each output holds:
- Input sample k of a frame is written to address bitrev(k).
- Output j of the following frame period is therefore input sample bitrev(j).

Reset behaviour:
- Reset (at power-up or mid-frame) clears cnt=0, bank=0, primed=0, o_strb=0, o_data=0, o_sof=0, o_eof=0.
- Memory contents are not cleared. They are never exposed because primed=0.

## Timing
- Cycle T: i_strb=1 with primed=1 drives the read.
- Cycle T+1: memory dout is valid; it is captured into the o_data register.
- Cycle T+2: o_strb=1 for exactly one cycle, with o_data valid.
- Latency from i_strb to the corresponding o_strb is 2 cycles.
- Sample latency is N input strobes plus 2 cycles.
- With back-to-back input strobes, o_strb is also back-to-back, delayed by 2 cycles.
- The strobe that completes a frame (cnt == N-1) both reads the last natural-order sample of the old read bank and writes the last sample of the current write bank. The bank toggle takes effect from the next strobe.
- The first strobe after primed becomes 1 reads address 0 of the just-filled bank.
- i_strb while n_reset=0 is ignored.

## Configuration
- FFT_REORDER_SOF_EN defined:
  - Adds the o_sof and o_eof ports.
  - Both are registered and aligned with o_strb.
  - o_sof=1 on the o_strb whose read address was 0.
  - o_eof=1 on the o_strb whose read address was N-1.
  - Both are 0 at all other times and at reset.
- FFT_REORDER_SOF_EN not defined: the ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared FFT package holds:
  - FFT_LOG2N default constant.
  - Sample-packing field positions (real low half, imag high half).
  - bitrev function, parameterised by LOG2N.
- One sub-module is natural: the existing mem_single (WD, DEPTH=N), instantiated twice.
  - The write memory gets cs=we=i_strb.
  - The read memory gets cs=i_strb&primed, we=0.
  - The addr and cs mux is selected by bank.
- Top-level registers: counter, bank, primed, a 2-deep strobe/marker pipeline, and the o_data register.

## Test plan
All scenarios use LOG2N=3 unless stated.
1. Reset, then 8 strobes with i_data=0..7 -> no o_strb, primed=1, bank=1.
2. Continue with 8 strobes of data 8..15 -> o_data sequence 0,4,2,6,1,5,3,7, each o_strb exactly 2 cycles after its i_strb. A third frame then yields 8,12,10,14,9,13,11,15.
3. Back-to-back strobes versus strobes spaced 5 cycles apart (random gaps 0..6) -> identical o_data sequence; every o_strb is at i_strb+2; o_data is held between strobes.
4. Deassert n_reset after 13 strobes (mid second frame) -> all outputs are 0 immediately. The next 8 strobes produce no o_strb, and the frame after that reorders correctly.
5. With FFT_REORDER_SOF_EN: o_sof=1 only with the output equal to data 0 (bin 0) and o_eof=1 only with data 7, per frame. Compiled without the macro, the ports are absent and scenarios 1-4 still pass.
6. LOG2N=10, two frames of random data -> output j of frame 2 equals input bitrev10(j) of frame 1, for all 1024 j.
